cpu_axi_arbiter: RTL and testbench

//  Shares the single AXI3 master port of the CPU top between the instruction-fetch port (read-only) and the

---
 rtl/cpu_axi_arbiter_pkg.sv | 41 ++++
 rtl/cpu_axi_rr_pick.sv | 40 ++++
 rtl/cpu_axi_arbiter.sv | 214 +++++++++++++++++++++
 tb/tb_cpu_axi_arbiter.sv | 381 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_axi_arbiter_pkg.sv
// Shared AXI3 constants, default IDs, arbiter FSM encoding and the
// byte-enable to transfer-size helper used by cpu_axi_arbiter.
package cpu_axi_arbiter_pkg;

  localparam logic [1:0] AXI_BURST_INCR  = 2'b01;
  localparam logic [1:0] AXI_LOCK_NORMAL = 2'b00;
  localparam logic [3:0] AXI_CACHE_NONE  = 4'b0000;
  localparam logic [2:0] AXI_PROT_NONE   = 3'b000;
  localparam logic [7:0] AXI_LEN_SINGLE  = 8'd0;

  localparam logic [2:0] AXI_SIZE_1B = 3'd0;
  localparam logic [2:0] AXI_SIZE_2B = 3'd1;
  localparam logic [2:0] AXI_SIZE_4B = 3'd2;

  localparam logic [3:0] DEF_INST_ID = 4'h0;
  localparam logic [3:0] DEF_DATA_ID = 4'h1;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_RADDR = 3'd1,
    ST_RDATA = 3'd2,
    ST_WADDR = 3'd3,
    ST_WRESP = 3'd4,
    ST_RESP  = 3'd5
  } arb_state_e;

  // Three enabled lanes is not a legal AXI size; it is widened to a word.
  function automatic logic [2:0] size_from_be(input logic [3:0] be);
    logic [2:0] cnt;
    cnt = 3'd0;
    for (int i = 0; i < 4; i++) begin
      cnt = cnt + {2'b00, be[i]};
    end
    case (cnt)
      3'd4, 3'd3: size_from_be = AXI_SIZE_4B;
      3'd2:       size_from_be = AXI_SIZE_2B;
      default:    size_from_be = AXI_SIZE_1B;
    endcase
  endfunction

endpackage

// File: rtl/cpu_axi_rr_pick.sv
// Two-way grant between the instruction and data ports: fixed data priority,
// or round-robin where the last-granted port loses a tie.
module cpu_axi_rr_pick #(
  parameter bit ARB_RR = 1'b0
) (
  input  logic aclk,
  input  logic aresetn,
  input  logic req_inst,
  input  logic req_data,
  input  logic upd_en,
  input  logic upd_data,
  output logic gnt_any,
  output logic gnt_data
);

  logic last_data_q;
  logic last_data_d;

  always_comb begin
    gnt_any  = req_inst | req_data;
    gnt_data = req_data & (~req_inst | ~ARB_RR | ~last_data_q);
  end

  always_comb begin
    last_data_d = last_data_q;
    if (upd_en) begin
      last_data_d = upd_data;
    end
  end

  // Reset as "inst was last" so data wins the first tie.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      last_data_q <= 1'b0;
    end else begin
      last_data_q <= last_data_d;
    end
  end

endmodule

// File: rtl/cpu_axi_arbiter.sv
// Shares one AXI3 master port between the instruction-fetch and data-access
// ports, one single-beat transaction at a time, with registered AXI requests.
module cpu_axi_arbiter
  import cpu_axi_arbiter_pkg::*;
#(
  parameter bit         ARB_RR  = 1'b0,
  parameter logic [3:0] INST_ID = DEF_INST_ID,
  parameter logic [3:0] DATA_ID = DEF_DATA_ID
) (
  input  logic        aclk,
  input  logic        aresetn,
  input  logic        iaccess_req,
  input  logic [31:0] iaccess_addr,
  output logic        iaccess_valid,
  output logic [31:0] iaccess_rdata,
  input  logic [3:0]  daccess_ren,
  input  logic [3:0]  daccess_wen,
  input  logic [31:0] daccess_addr,
  input  logic [31:0] daccess_wdata,
  output logic        daccess_valid,
  output logic [31:0] daccess_rdata,
  output logic        daccess_wresp,
  output logic [3:0]  arid,
  output logic [31:0] araddr,
  output logic [7:0]  arlen,
  output logic [2:0]  arsize,
  output logic [1:0]  arburst,
  output logic [1:0]  arlock,
  output logic [3:0]  arcache,
  output logic [2:0]  arprot,
  output logic        arvalid,
  input  logic        arready,
  input  logic [3:0]  rid,
  input  logic [31:0] rdata,
  input  logic [1:0]  rresp,
  input  logic        rlast,
  input  logic        rvalid,
  output logic        rready,
  output logic [3:0]  awid,
  output logic [31:0] awaddr,
  output logic [7:0]  awlen,
  output logic [2:0]  awsize,
  output logic [1:0]  awburst,
  output logic [1:0]  awlock,
  output logic [3:0]  awcache,
  output logic [2:0]  awprot,
  output logic        awvalid,
  input  logic        awready,
  output logic [3:0]  wid,
  output logic [31:0] wdata,
  output logic [3:0]  wstrb,
  output logic        wlast,
  output logic        wvalid,
  input  logic        wready,
  input  logic [3:0]  bid,
  input  logic [1:0]  bresp,
  input  logic        bvalid,
  output logic        bready
);

  arb_state_e  state_q, state_d;
  logic        port_data_q, port_data_d;
  logic        is_wr_q, is_wr_d;
  logic [3:0]  id_q, id_d;
  logic [31:0] addr_q, addr_d;
  logic [2:0]  size_q, size_d;
  logic [31:0] wdata_q, wdata_d;
  logic [3:0]  strb_q, strb_d;
  logic        aw_done_q, aw_done_d;
  logic        w_done_q, w_done_d;
  logic [31:0] irdata_q, irdata_d;
  logic [31:0] drdata_q, drdata_d;

  logic data_wr, data_rd, gnt_any, gnt_data, grant;
  logic aw_hs, w_hs, aw_fin, w_fin, r_fin;
  logic unused_inputs;

  assign unused_inputs = ^{rid, rresp, bid, bresp};

  // A simultaneous write wins over the read enables.
  assign data_wr = |daccess_wen;
  assign data_rd = |daccess_ren;
  assign grant   = (state_q == ST_IDLE) & gnt_any;
  assign aw_hs   = awvalid & awready;
  assign w_hs    = wvalid & wready;
  assign aw_fin  = aw_done_q | aw_hs;
  assign w_fin   = w_done_q | w_hs;
  assign r_fin   = (state_q == ST_RDATA) & rvalid & rlast;

  cpu_axi_rr_pick #(
    .ARB_RR (ARB_RR)
  ) u_pick (
    .aclk     (aclk),
    .aresetn  (aresetn),
    .req_inst (iaccess_req),
    .req_data (data_wr | data_rd),
    .upd_en   (state_q == ST_RESP),
    .upd_data (port_data_q),
    .gnt_any  (gnt_any),
    .gnt_data (gnt_data)
  );

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state_q     <= ST_IDLE;
      port_data_q <= 1'b0;
      is_wr_q     <= 1'b0;
      id_q        <= 4'h0;
      addr_q      <= 32'h0;
      size_q      <= 3'd0;
      wdata_q     <= 32'h0;
      strb_q      <= 4'h0;
      aw_done_q   <= 1'b0;
      w_done_q    <= 1'b0;
      irdata_q    <= 32'h0;
      drdata_q    <= 32'h0;
    end else begin
      state_q     <= state_d;
      port_data_q <= port_data_d;
      is_wr_q     <= is_wr_d;
      id_q        <= id_d;
      addr_q      <= addr_d;
      size_q      <= size_d;
      wdata_q     <= wdata_d;
      strb_q      <= strb_d;
      aw_done_q   <= aw_done_d;
      w_done_q    <= w_done_d;
      irdata_q    <= irdata_d;
      drdata_q    <= drdata_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (gnt_any) state_d = (gnt_data & data_wr) ? ST_WADDR : ST_RADDR;
      ST_RADDR: if (arready) state_d = ST_RDATA;
      ST_RDATA: if (rvalid & rlast) state_d = ST_RESP;
      ST_WADDR: if (aw_fin & w_fin) state_d = ST_WRESP;
      ST_WRESP: if (bvalid) state_d = ST_RESP;
      ST_RESP:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    port_data_d = port_data_q;
    is_wr_d     = is_wr_q;
    id_d        = id_q;
    addr_d      = addr_q;
    size_d      = size_q;
    wdata_d     = wdata_q;
    strb_d      = strb_q;
    aw_done_d   = aw_done_q;
    w_done_d    = w_done_q;
    irdata_d    = irdata_q;
    drdata_d    = drdata_q;
    if (grant) begin
      port_data_d = gnt_data;
      is_wr_d     = gnt_data & data_wr;
      id_d        = gnt_data ? DATA_ID : INST_ID;
      addr_d      = gnt_data ? daccess_addr : iaccess_addr;
      size_d      = gnt_data ? size_from_be(data_wr ? daccess_wen : daccess_ren) : AXI_SIZE_4B;
      wdata_d     = daccess_wdata;
      strb_d      = (gnt_data & data_wr) ? daccess_wen : 4'h0;
      aw_done_d   = 1'b0;
      w_done_d    = 1'b0;
    end
    if (aw_hs) aw_done_d = 1'b1;
    if (w_hs)  w_done_d  = 1'b1;
    if (r_fin) begin
      if (port_data_q) drdata_d = rdata;
      else             irdata_d = rdata;
    end
  end

  always_comb begin
    arvalid       = (state_q == ST_RADDR);
    rready        = (state_q == ST_RDATA);
    awvalid       = (state_q == ST_WADDR) & ~aw_done_q;
    wvalid        = (state_q == ST_WADDR) & ~w_done_q;
    bready        = (state_q == ST_WRESP);
    iaccess_valid = (state_q == ST_RESP) & ~port_data_q;
    daccess_valid = (state_q == ST_RESP) & port_data_q & ~is_wr_q;
    daccess_wresp = (state_q == ST_RESP) & port_data_q & is_wr_q;
  end

  assign iaccess_rdata = irdata_q;
  assign daccess_rdata = drdata_q;

  assign arid    = id_q;
  assign araddr  = addr_q;
  assign arlen   = AXI_LEN_SINGLE;
  assign arsize  = size_q;
  assign arburst = AXI_BURST_INCR;
  assign arlock  = AXI_LOCK_NORMAL;
  assign arcache = AXI_CACHE_NONE;
  assign arprot  = AXI_PROT_NONE;

  assign awid    = id_q;
  assign awaddr  = addr_q;
  assign awlen   = AXI_LEN_SINGLE;
  assign awsize  = size_q;
  assign awburst = AXI_BURST_INCR;
  assign awlock  = AXI_LOCK_NORMAL;
  assign awcache = AXI_CACHE_NONE;
  assign awprot  = AXI_PROT_NONE;

  assign wid     = id_q;
  assign wdata   = wdata_q;
  assign wstrb   = strb_q;
  assign wlast   = 1'b1;

endmodule

// File: tb/tb_cpu_axi_arbiter.sv
// Directed bench: a fixed-priority arbiter driven by a scripted slave, plus a
// round-robin instance against an always-ready slave for the alternation check.
module tb_cpu_axi_arbiter;

  logic aclk, aresetn;
  int n_chk, n_fail;

  logic        iaccess_req;
  logic [31:0] iaccess_addr;
  logic        iaccess_valid;
  logic [31:0] iaccess_rdata;
  logic [3:0]  daccess_ren, daccess_wen;
  logic [31:0] daccess_addr, daccess_wdata;
  logic        daccess_valid, daccess_wresp;
  logic [31:0] daccess_rdata;
  logic [3:0]  arid, awid, wid, wstrb, arcache, awcache;
  logic [31:0] araddr, awaddr, wdata;
  logic [7:0]  arlen, awlen;
  logic [2:0]  arsize, awsize, arprot, awprot;
  logic [1:0]  arburst, awburst, arlock, awlock;
  logic        arvalid, rready, awvalid, wvalid, wlast, bready;
  logic        arready, rlast, rvalid, awready, wready, bvalid;
  logic [31:0] rdata;

  logic        ireq_1;
  logic [3:0]  dren_1;
  logic        ivalid_1, dvalid_1, dwresp_1;
  logic [31:0] irdata_1, drdata_1;
  logic [3:0]  arid_1, awid_1, wid_1, wstrb_1, arcache_1, awcache_1;
  logic [31:0] araddr_1, awaddr_1, wdata_1;
  logic [7:0]  arlen_1, awlen_1;
  logic [2:0]  arsize_1, awsize_1, arprot_1, awprot_1;
  logic [1:0]  arburst_1, awburst_1, arlock_1, awlock_1;
  logic        arvalid_1, rready_1, awvalid_1, wvalid_1, wlast_1, bready_1;

  cpu_axi_arbiter #(.ARB_RR(1'b0)) dut (
    .aclk(aclk), .aresetn(aresetn),
    .iaccess_req(iaccess_req), .iaccess_addr(iaccess_addr),
    .iaccess_valid(iaccess_valid), .iaccess_rdata(iaccess_rdata),
    .daccess_ren(daccess_ren), .daccess_wen(daccess_wen),
    .daccess_addr(daccess_addr), .daccess_wdata(daccess_wdata),
    .daccess_valid(daccess_valid), .daccess_rdata(daccess_rdata),
    .daccess_wresp(daccess_wresp),
    .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize),
    .arburst(arburst), .arlock(arlock), .arcache(arcache), .arprot(arprot),
    .arvalid(arvalid), .arready(arready),
    .rid(4'h0), .rdata(rdata), .rresp(2'b00), .rlast(rlast), .rvalid(rvalid),
    .rready(rready),
    .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize),
    .awburst(awburst), .awlock(awlock), .awcache(awcache), .awprot(awprot),
    .awvalid(awvalid), .awready(awready),
    .wid(wid), .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid),
    .wready(wready),
    .bid(4'h0), .bresp(2'b00), .bvalid(bvalid), .bready(bready)
  );

  cpu_axi_arbiter #(.ARB_RR(1'b1)) dut_rr (
    .aclk(aclk), .aresetn(aresetn),
    .iaccess_req(ireq_1), .iaccess_addr(32'h1C000000),
    .iaccess_valid(ivalid_1), .iaccess_rdata(irdata_1),
    .daccess_ren(dren_1), .daccess_wen(4'h0),
    .daccess_addr(32'h1C000400), .daccess_wdata(32'h0),
    .daccess_valid(dvalid_1), .daccess_rdata(drdata_1),
    .daccess_wresp(dwresp_1),
    .arid(arid_1), .araddr(araddr_1), .arlen(arlen_1), .arsize(arsize_1),
    .arburst(arburst_1), .arlock(arlock_1), .arcache(arcache_1), .arprot(arprot_1),
    .arvalid(arvalid_1), .arready(1'b1),
    .rid(4'h0), .rdata(32'h5A5A5A5A), .rresp(2'b00), .rlast(1'b1), .rvalid(1'b1),
    .rready(rready_1),
    .awid(awid_1), .awaddr(awaddr_1), .awlen(awlen_1), .awsize(awsize_1),
    .awburst(awburst_1), .awlock(awlock_1), .awcache(awcache_1), .awprot(awprot_1),
    .awvalid(awvalid_1), .awready(1'b1),
    .wid(wid_1), .wdata(wdata_1), .wstrb(wstrb_1), .wlast(wlast_1), .wvalid(wvalid_1),
    .wready(1'b1),
    .bid(4'h0), .bresp(2'b00), .bvalid(1'b1), .bready(bready_1)
  );

  initial aclk = 1'b0;
  always #5 aclk = ~aclk;

  // Acts as the read slave: waits for AR, accepts after ar_delay cycles,
  // returns data after r_delay cycles. Returns at the negedge of RESP.
  task automatic serve_read(input logic [31:0] d, input int ar_delay, input int r_delay,
                            output logic [3:0] id, output logic [31:0] addr,
                            output logic [2:0] size, output int waited);
    waited = 0;
    while (!arvalid && waited < 20) begin
      @(negedge aclk);
      waited++;
    end
    n_chk++;
    if (arvalid !== 1'b1) begin
      n_fail++;
      $display("FAIL ar_wait: arvalid=%0b, required 1", arvalid);
    end
    id = arid; addr = araddr; size = arsize;
    repeat (ar_delay) @(negedge aclk);
    arready = 1'b1;
    @(negedge aclk);
    arready = 1'b0;
    for (int i = 0; i < r_delay; i++) begin
      n_chk++;
      if (rready !== 1'b1) begin
        n_fail++;
        $display("FAIL rready_hold: rready=%0b at wait %0d, required 1", rready, i);
      end
      @(negedge aclk);
    end
    rdata = d; rlast = 1'b1; rvalid = 1'b1;
    @(negedge aclk);
    rvalid = 1'b0; rlast = 1'b0;
  endtask

  task automatic test_reset();
    n_chk++;
    if ({arvalid, rready, awvalid, wvalid, bready, iaccess_valid, daccess_valid, daccess_wresp} !== 8'h00) begin
      n_fail++;
      $display("FAIL reset_ctrl: got %b, required 00000000",
               {arvalid, rready, awvalid, wvalid, bready, iaccess_valid, daccess_valid, daccess_wresp});
    end
    n_chk++;
    if (iaccess_rdata !== 32'h0 || daccess_rdata !== 32'h0) begin
      n_fail++;
      $display("FAIL reset_rdata: i=%h d=%h, required 0", iaccess_rdata, daccess_rdata);
    end
    n_chk++;
    if ({arlen, arburst, wlast} !== {8'd0, 2'b01, 1'b1}) begin
      n_fail++;
      $display("FAIL consts: arlen=%0d arburst=%b wlast=%b", arlen, arburst, wlast);
    end
  endtask

  task automatic test_inst_read();
    logic [3:0] id; logic [31:0] a; logic [2:0] s; int w;
    iaccess_req = 1'b1; iaccess_addr = 32'h1C000000;
    serve_read(32'h02800C0C, 0, 0, id, a, s, w);
    n_chk++;
    if (w !== 1) begin n_fail++; $display("FAIL inst_ar_latency: %0d cycles, required 1", w); end
    n_chk++;
    if ({id, a, s} !== {4'h0, 32'h1C000000, 3'd2}) begin
      n_fail++;
      $display("FAIL inst_ar_fields: id=%h addr=%h size=%0d, required 0 1c000000 2", id, a, s);
    end
    n_chk++;
    if (iaccess_valid !== 1'b1 || iaccess_rdata !== 32'h02800C0C || daccess_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL inst_resp: valid=%0b rdata=%h dvalid=%0b, required 1 02800c0c 0",
               iaccess_valid, iaccess_rdata, daccess_valid);
    end
    iaccess_req = 1'b0;
    @(negedge aclk);
    n_chk++;
    if (iaccess_valid !== 1'b0 || iaccess_rdata !== 32'h02800C0C) begin
      n_fail++;
      $display("FAIL inst_pulse: valid=%0b rdata=%h, required 0 02800c0c", iaccess_valid, iaccess_rdata);
    end
  endtask

  task automatic test_fixed_priority();
    logic [3:0] id; logic [31:0] a; logic [2:0] s; int w;
    iaccess_req = 1'b1; iaccess_addr = 32'h1C000010;
    daccess_ren = 4'b1111; daccess_addr = 32'h1C000800;
    serve_read(32'hDEAD0001, 0, 0, id, a, s, w);
    n_chk++;
    if (id !== 4'h1 || a !== 32'h1C000800) begin
      n_fail++;
      $display("FAIL prio_first: id=%h addr=%h, required 1 1c000800", id, a);
    end
    n_chk++;
    if (daccess_valid !== 1'b1 || iaccess_valid !== 1'b0 || daccess_rdata !== 32'hDEAD0001) begin
      n_fail++;
      $display("FAIL prio_dresp: dvalid=%0b ivalid=%0b rdata=%h, required 1 0 dead0001",
               daccess_valid, iaccess_valid, daccess_rdata);
    end
    daccess_ren = 4'b0000;
    serve_read(32'hBEEF0002, 0, 0, id, a, s, w);
    n_chk++;
    if (id !== 4'h0 || a !== 32'h1C000010 || iaccess_valid !== 1'b1 || iaccess_rdata !== 32'hBEEF0002) begin
      n_fail++;
      $display("FAIL prio_second: id=%h addr=%h ivalid=%0b rdata=%h, required 0 1c000010 1 beef0002",
               id, a, iaccess_valid, iaccess_rdata);
    end
    iaccess_req = 1'b0;
    @(negedge aclk);
  endtask

  task automatic test_round_robin();
    logic [3:0] ids [4];
    int n;
    n = 0;
    ireq_1 = 1'b1; dren_1 = 4'b1111;
    for (int c = 0; c < 24 && n < 4; c++) begin
      @(negedge aclk);
      if (arvalid_1) begin
        ids[n] = arid_1;
        n++;
      end
    end
    ireq_1 = 1'b0; dren_1 = 4'b0000;
    n_chk++;
    if (n !== 4) begin
      n_fail++;
      $display("FAIL rr_count: %0d grants, required 4", n);
    end else begin
      n_chk++;
      if ({ids[0], ids[1], ids[2], ids[3]} !== {4'h1, 4'h0, 4'h1, 4'h0}) begin
        n_fail++;
        $display("FAIL rr_order: %h %h %h %h, required 1 0 1 0", ids[0], ids[1], ids[2], ids[3]);
      end
    end
    repeat (4) @(negedge aclk);
  endtask

  task automatic test_write_aw_delay();
    awready = 1'b0; wready = 1'b1;
    daccess_wen = 4'b0011; daccess_addr = 32'h1C000102; daccess_wdata = 32'hAABB1234;
    @(negedge aclk);
    n_chk++;
    if ({awvalid, wvalid} !== 2'b11 || awaddr !== 32'h1C000102 || awsize !== 3'd1 ||
        wstrb !== 4'b0011 || wdata !== 32'hAABB1234 || awid !== 4'h1 || wid !== 4'h1) begin
      n_fail++;
      $display("FAIL wr_issue: aw=%0b w=%0b addr=%h size=%0d strb=%b data=%h awid=%h wid=%h",
               awvalid, wvalid, awaddr, awsize, wstrb, wdata, awid, wid);
    end
    @(negedge aclk);
    n_chk++;
    if ({awvalid, wvalid} !== 2'b10) begin
      n_fail++;
      $display("FAIL wr_w_drop: aw=%0b w=%0b, required 1 0", awvalid, wvalid);
    end
    @(negedge aclk);
    @(negedge aclk);
    n_chk++;
    if ({awvalid, wvalid, bready} !== 3'b100) begin
      n_fail++;
      $display("FAIL wr_aw_hold: aw=%0b w=%0b b=%0b, required 1 0 0", awvalid, wvalid, bready);
    end
    awready = 1'b1;
    @(negedge aclk);
    awready = 1'b0; wready = 1'b0;
    n_chk++;
    if ({awvalid, bready} !== 2'b01) begin
      n_fail++;
      $display("FAIL wr_bwait: aw=%0b bready=%0b, required 0 1", awvalid, bready);
    end
    bvalid = 1'b1;
    @(negedge aclk);
    bvalid = 1'b0;
    n_chk++;
    if ({daccess_wresp, daccess_valid, iaccess_valid} !== 3'b100) begin
      n_fail++;
      $display("FAIL wr_resp: wresp=%0b dvalid=%0b ivalid=%0b, required 1 0 0",
               daccess_wresp, daccess_valid, iaccess_valid);
    end
    daccess_wen = 4'b0000;
    @(negedge aclk);
    n_chk++;
    if (daccess_wresp !== 1'b0) begin
      n_fail++;
      $display("FAIL wr_pulse: wresp=%0b, required 0", daccess_wresp);
    end
  endtask

  task automatic test_byte_read_slow();
    logic [3:0] id; logic [31:0] a; logic [2:0] s; int w; int pulses;
    daccess_ren = 4'b0100; daccess_addr = 32'h1C000003;
    serve_read(32'h00CC0000, 0, 5, id, a, s, w);
    n_chk++;
    if ({id, a, s} !== {4'h1, 32'h1C000003, 3'd0}) begin
      n_fail++;
      $display("FAIL byte_ar: id=%h addr=%h size=%0d, required 1 1c000003 0", id, a, s);
    end
    n_chk++;
    if (daccess_valid !== 1'b1 || daccess_rdata !== 32'h00CC0000 || iaccess_rdata !== 32'hBEEF0002) begin
      n_fail++;
      $display("FAIL byte_resp: dvalid=%0b drdata=%h irdata=%h, required 1 00cc0000 beef0002",
               daccess_valid, daccess_rdata, iaccess_rdata);
    end
    daccess_ren = 4'b0000;
    pulses = 0;
    repeat (3) begin
      @(negedge aclk);
      pulses += int'(daccess_valid);
    end
    n_chk++;
    if (pulses !== 0) begin
      n_fail++;
      $display("FAIL byte_single: %0d extra pulses, required 0", pulses);
    end
  endtask

  task automatic test_write_beats_read();
    int ar_hs, wr_cnt, dv_cnt;
    logic [2:0] sz;
    ar_hs = 0; wr_cnt = 0; dv_cnt = 0; sz = 3'd7;
    arready = 1'b1; awready = 1'b1; wready = 1'b1; bvalid = 1'b1;
    daccess_wen = 4'b1111; daccess_ren = 4'b1111;
    daccess_addr = 32'h1C000200; daccess_wdata = 32'h11223344;
    for (int c = 0; c < 12; c++) begin
      @(negedge aclk);
      if (arvalid && arready) ar_hs++;
      if (awvalid) sz = awsize;
      dv_cnt += int'(daccess_valid);
      if (daccess_wresp) begin
        wr_cnt++;
        daccess_wen = 4'b0000; daccess_ren = 4'b0000;
      end
    end
    arready = 1'b0; awready = 1'b0; wready = 1'b0; bvalid = 1'b0;
    daccess_wen = 4'b0000; daccess_ren = 4'b0000;
    n_chk++;
    if (ar_hs !== 0 || wr_cnt !== 1 || dv_cnt !== 0 || sz !== 3'd2) begin
      n_fail++;
      $display("FAIL wr_vs_rd: ar_hs=%0d wresp=%0d dvalid=%0d awsize=%0d, required 0 1 0 2",
               ar_hs, wr_cnt, dv_cnt, sz);
    end
  endtask

  task automatic test_async_reset();
    logic [3:0] id; logic [31:0] a; logic [2:0] s; int w;
    iaccess_req = 1'b1; iaccess_addr = 32'h1C000040;
    w = 0;
    while (!arvalid && w < 20) begin
      @(negedge aclk);
      w++;
    end
    arready = 1'b1;
    @(negedge aclk);
    arready = 1'b0;
    n_chk++;
    if (rready !== 1'b1) begin
      n_fail++;
      $display("FAIL rst_pre: rready=%0b, required 1", rready);
    end
    #2 aresetn = 1'b0;
    #1;
    n_chk++;
    if ({rready, arvalid, iaccess_valid, daccess_valid, daccess_wresp} !== 5'b00000 ||
        iaccess_rdata !== 32'h0) begin
      n_fail++;
      $display("FAIL rst_async: ctrl=%b irdata=%h, required 00000 0",
               {rready, arvalid, iaccess_valid, daccess_valid, daccess_wresp}, iaccess_rdata);
    end
    @(negedge aclk);
    @(negedge aclk);
    aresetn = 1'b1;
    serve_read(32'h12345678, 1, 2, id, a, s, w);
    n_chk++;
    if (a !== 32'h1C000040 || id !== 4'h0 || iaccess_valid !== 1'b1 || iaccess_rdata !== 32'h12345678) begin
      n_fail++;
      $display("FAIL rst_recover: addr=%h id=%h ivalid=%0b rdata=%h, required 1c000040 0 1 12345678",
               a, id, iaccess_valid, iaccess_rdata);
    end
    iaccess_req = 1'b0;
    @(negedge aclk);
  endtask

  initial begin
    n_chk = 0; n_fail = 0;
    aresetn = 1'b0;
    iaccess_req = 1'b0; iaccess_addr = 32'h0;
    daccess_ren = 4'h0; daccess_wen = 4'h0; daccess_addr = 32'h0; daccess_wdata = 32'h0;
    arready = 1'b0; rvalid = 1'b0; rlast = 1'b0; rdata = 32'h0;
    awready = 1'b0; wready = 1'b0; bvalid = 1'b0;
    ireq_1 = 1'b0; dren_1 = 4'h0;
    repeat (3) @(negedge aclk);
    test_reset();
    aresetn = 1'b1;
    @(negedge aclk);
    test_inst_read();
    test_fixed_priority();
    test_round_robin();
    test_write_aw_delay();
    test_byte_read_slow();
    test_write_beats_read();
    test_async_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
